// File: rtl/ac97_pkg.sv
// ac97_pkg: definitions shared by the AC-link output controller.
//   - FSM state encodings (WAIT_READY, CMD, RUN)
//   - codec register addresses written during initialisation
//   - command-frame tag and frame geometry constants
//   - frame payload struct and slot-packing helpers
package ac97_pkg;

    localparam int unsigned FRAME_BITS = 256;
    localparam int unsigned TAG_BITS   = 16;
    localparam int unsigned SLOT_BITS  = 20;

    localparam logic [1:0] ST_WAIT_READY = 2'd0;
    localparam logic [1:0] ST_CMD        = 2'd1;
    localparam logic [1:0] ST_RUN        = 2'd2;

    localparam logic [6:0] REG_MASTER_VOL = 7'h02;
    localparam logic [6:0] REG_HP_VOL     = 7'h04;
    localparam logic [6:0] REG_PCM_VOL    = 7'h18;

    // Frame valid, slot 1 valid, slot 2 valid.
    localparam logic [15:0] TAG_CMD = 16'hE000;

    // Transmitted payload; slots 5..12 are always zero and are not stored.
    typedef struct packed {
        logic [15:0] tag;
        logic [19:0] slot1;
        logic [19:0] slot2;
        logic [19:0] slot3;
        logic [19:0] slot4;
    } ac97_frame_t;

    // Slot 1 command address: bit 19 = 0 selects a write.
    function automatic logic [19:0] cmd_addr_slot(input logic [6:0] addr);
        return {1'b0, addr, 12'h000};
    endfunction

    function automatic logic [19:0] cmd_data_slot(input logic [15:0] data);
        return {data, 4'h0};
    endfunction

endpackage

// File: rtl/ac97_link_ctrl_if.sv
// ac97_link_ctrl_if: signal bundle between the slot formatter / codec-status side
// and the AC-link controller.
//   codec_ready          codec-ready level (synchronous to the bit clock)
//   slot0_in..slot4_in   slot words for RUN frames (slot0 bits [19:16] ignored)
//   sync, sdata_out      AC-link serial outputs
//   sample_req           one-cycle pulse on the last bit of each frame
//   init_done            high while the controller is passing audio
// Modports: master = formatter/codec side, slave = controller.
interface ac97_link_ctrl_if;

    logic        codec_ready;
    logic [19:0] slot0_in;
    logic [19:0] slot1_in;
    logic [19:0] slot2_in;
    logic [19:0] slot3_in;
    logic [19:0] slot4_in;
    logic        sync;
    logic        sdata_out;
    logic        sample_req;
    logic        init_done;

    modport master (
        output codec_ready, slot0_in, slot1_in, slot2_in, slot3_in, slot4_in,
        input  sync, sdata_out, sample_req, init_done
    );

    modport slave (
        input  codec_ready, slot0_in, slot1_in, slot2_in, slot3_in, slot4_in,
        output sync, sdata_out, sample_req, init_done
    );

endinterface

// File: rtl/ac97_frame_ser.sv
// ac97_frame_ser: AC-link frame serialiser.
// Ports:
//   clk, rst_n     bit clock, asynchronous active-low reset
//   i_load         load strobe, asserted in the last bit cycle of a frame
//   i_frame        payload for the next frame (tag + slots 1..4)
//   o_frame_end    high while the bit counter is 255
//   o_sync         SYNC, high during frame bits 0..15
//   o_sdata        SDATA_OUT, MSB first
//   o_sample_req   one-cycle pulse on frame bit 255
// Outputs are registered and computed from the counter's next value so that they
// line up with the counter. The first bit cycle after reset release shows the reset
// values (sync=0) because no edge has occurred yet.
module ac97_frame_ser
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  ac97_frame_t i_frame,
    output logic        o_frame_end,
    output logic        o_sync,
    output logic        o_sdata,
    output logic        o_sample_req
);

    localparam int unsigned PAYLOAD_BITS = TAG_BITS + 4 * SLOT_BITS;

    logic [7:0]            r_bit_cnt;
    logic [7:0]            w_bit_nxt;
    ac97_frame_t           r_shadow;
    ac97_frame_t           w_src;
    logic [FRAME_BITS-1:0] w_frame_vec;
    logic                  r_sync;
    logic                  r_sdata;
    logic                  r_sample_req;

    assign w_bit_nxt   = r_bit_cnt + 8'd1;
    // Bit 0 of a new frame is produced on the load edge, so it must come from the
    // incoming payload rather than the shadow being replaced.
    assign w_src       = i_load ? i_frame : r_shadow;
    assign w_frame_vec = {w_src, {(FRAME_BITS - PAYLOAD_BITS){1'b0}}};
    assign o_frame_end = (r_bit_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 8'd0;
            r_shadow     <= '0;
            r_sync       <= 1'b0;
            r_sdata      <= 1'b0;
            r_sample_req <= 1'b0;
        end else begin
            r_bit_cnt    <= w_bit_nxt;
            if (i_load) begin
                r_shadow <= i_frame;
            end
            r_sync       <= (w_bit_nxt < 8'(TAG_BITS));
            // Frame bit k sits at vector index 255-k, i.e. ~k.
            r_sdata      <= w_frame_vec[~w_bit_nxt];
            r_sample_req <= (w_bit_nxt == 8'hFF);
        end
    end

    assign o_sync       = r_sync;
    assign o_sdata      = r_sdata;
    assign o_sample_req = r_sample_req;

endmodule

// File: rtl/ac97_link_ctrl.sv
// ac97_link_ctrl: AC'97 AC-link output frame controller.
// Ports:
//   clk     AC-link bit clock
//   rst_n   asynchronous active-low reset
//   bus     ac97_link_ctrl_if.slave (codec_ready, slot inputs, AC-link outputs)
// Configuration macro AC97_INIT_SEQ_EN:
//   defined   - after codec_ready, three command frames write master volume,
//               headphone volume and PCM volume before audio is passed; the
//               MASTER_VOL/HP_VOL/PCM_VOL parameters exist only in this build.
//   undefined - WAIT_READY goes straight to RUN.
// The FSM only advances at frame boundaries (bit 255), and the payload for the next
// frame is derived from the state being entered.
module ac97_link_ctrl
    import ac97_pkg::*;
`ifdef AC97_INIT_SEQ_EN
#(
    parameter logic [15:0] MASTER_VOL = 16'h0000,
    parameter logic [15:0] HP_VOL     = 16'h0000,
    parameter logic [15:0] PCM_VOL    = 16'h0808
)
`endif
(
    input logic          clk,
    input logic          rst_n,
    ac97_link_ctrl_if.slave bus
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        w_frame_end;
    ac97_frame_t w_frame_nxt;

`ifdef AC97_INIT_SEQ_EN
    logic [1:0]  r_cmd_idx;
    logic [1:0]  w_cmd_idx_nxt;
    logic [6:0]  w_cmd_addr;
    logic [15:0] w_cmd_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_idx_nxt = r_cmd_idx;
        if (w_frame_end) begin
            if (!bus.codec_ready) begin
                w_state_nxt   = ST_WAIT_READY;
                w_cmd_idx_nxt = 2'd0;
            end else begin
                case (r_state)
                    ST_WAIT_READY: begin
                        w_state_nxt   = ST_CMD;
                        w_cmd_idx_nxt = 2'd0;
                    end
                    ST_CMD: begin
                        if (r_cmd_idx == 2'd2) begin
                            w_state_nxt   = ST_RUN;
                            w_cmd_idx_nxt = 2'd0;
                        end else begin
                            w_cmd_idx_nxt = r_cmd_idx + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Command table indexed by the command about to be sent.
    always_comb begin
        w_cmd_addr = REG_MASTER_VOL;
        w_cmd_data = MASTER_VOL;
        case (w_cmd_idx_nxt)
            2'd1: begin
                w_cmd_addr = REG_HP_VOL;
                w_cmd_data = HP_VOL;
            end
            2'd2: begin
                w_cmd_addr = REG_PCM_VOL;
                w_cmd_data = PCM_VOL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_idx <= 2'd0;
        end else begin
            r_cmd_idx <= w_cmd_idx_nxt;
        end
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        if (w_frame_end) begin
            w_state_nxt = bus.codec_ready ? ST_RUN : ST_WAIT_READY;
        end
    end
`endif

    // Payload for the frame that starts after this boundary.
    always_comb begin
        w_frame_nxt = '0;
        case (w_state_nxt)
`ifdef AC97_INIT_SEQ_EN
            ST_CMD: begin
                w_frame_nxt.tag   = TAG_CMD;
                w_frame_nxt.slot1 = cmd_addr_slot(w_cmd_addr);
                w_frame_nxt.slot2 = cmd_data_slot(w_cmd_data);
            end
`endif
            ST_RUN: begin
                w_frame_nxt.tag   = bus.slot0_in[15:0];
                w_frame_nxt.slot1 = bus.slot1_in;
                w_frame_nxt.slot2 = bus.slot2_in;
                w_frame_nxt.slot3 = bus.slot3_in;
                w_frame_nxt.slot4 = bus.slot4_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign bus.init_done = (r_state == ST_RUN);

    ac97_frame_ser u_frame_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_frame_end),
        .i_frame      (w_frame_nxt),
        .o_frame_end  (w_frame_end),
        .o_sync       (bus.sync),
        .o_sdata      (bus.sdata_out),
        .o_sample_req (bus.sample_req)
    );

endmodule

// File: tb/tb_ac97_link_ctrl.sv
// tb_ac97_link_ctrl: self-checking bench for ac97_link_ctrl.
// Each frame is captured bit by bit and compared against a frame-level model that
// counts consecutive codec_ready boundaries: zero frames while not ready, then the
// command frames (when AC97_INIT_SEQ_EN is defined), then RUN frames carrying the
// slot inputs present at the boundary.
module tb_ac97_link_ctrl;

`ifdef AC97_INIT_SEQ_EN
    localparam int CMD_FRAMES = 3;
`else
    localparam int CMD_FRAMES = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ac97_link_ctrl_if bus ();

    ac97_link_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    int           n_ready;
    logic         first_after_rst;
    logic [255:0] exp_frame;
    logic         exp_run;
    int           cmd_addr [3] = '{'h02, 'h04, 'h18};
    int           cmd_data [3] = '{'h0000, 'h0000, 'h0808};

    // Inputs applied at the boundary ending the current frame.
    logic        b_ready;
    logic [19:0] b_s0, b_s1, b_s2, b_s3, b_s4;

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] build_frame(input logic [15:0] tag, input logic [19:0] s1,
                                                 input logic [19:0] s2, input logic [19:0] s3,
                                                 input logic [19:0] s4);
        logic [255:0] f;
        f            = '0;
        f[255:240]   = tag;
        f[239:220]   = s1;
        f[219:200]   = s2;
        f[199:180]   = s3;
        f[179:160]   = s4;
        return f;
    endfunction

    task automatic model_boundary();
        if (!b_ready) n_ready = 0;
        else if (n_ready < 1000) n_ready++;
        if (n_ready == 0) begin
            exp_frame = '0;
            exp_run   = 1'b0;
        end else if (n_ready <= CMD_FRAMES) begin
            exp_frame = build_frame(16'hE000, 20'(cmd_addr[n_ready-1] * 4096),
                                    20'(cmd_data[n_ready-1] * 16), 20'h0, 20'h0);
            exp_run   = 1'b0;
        end else begin
            exp_frame = build_frame(b_s0[15:0], b_s1, b_s2, b_s3, b_s4);
            exp_run   = 1'b1;
        end
    endtask

    task automatic model_reset();
        n_ready         = 0;
        exp_frame       = '0;
        exp_run         = 1'b0;
        first_after_rst = 1'b1;
    endtask

    task automatic drive_boundary();
        bus.codec_ready = b_ready;
        bus.slot0_in    = b_s0;
        bus.slot1_in    = b_s1;
        bus.slot2_in    = b_s2;
        bus.slot3_in    = b_s3;
        bus.slot4_in    = b_s4;
    endtask

    task automatic rand_slots();
        b_s0 = 20'($urandom);
        b_s1 = 20'($urandom);
        b_s2 = 20'($urandom);
        b_s3 = 20'($urandom);
        b_s4 = 20'($urandom);
    endtask

    // Runs one frame from bit 0. rst_bit >= 0 asserts reset in that bit's cycle.
    // mid_apply drives the boundary values early (bit 100); junk scrambles inputs at bit 37.
    task automatic run_frame(input int rst_bit, input logic mid_apply, input logic junk);
        logic [255:0] sd_v, sy_v, sr_v, id_v, exp_sync;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            sd_v[255-k] = bus.sdata_out;
            sy_v[255-k] = bus.sync;
            sr_v[255-k] = bus.sample_req;
            id_v[255-k] = bus.init_done;
            if (k == rst_bit) begin
                #2 rst_n = 1'b0;
                #1 check_val("async_reset",
                             256'({bus.sync, bus.sdata_out, bus.sample_req, bus.init_done}), '0);
                repeat (2) @(posedge clk);
                #1 check_val("held_reset",
                             256'({bus.sync, bus.sdata_out, bus.sample_req, bus.init_done}), '0);
                rst_n = 1'b1;
                model_reset();
                return;
            end
            if (k == 37 && junk) begin
                bus.codec_ready = 1'($urandom_range(0, 1));
                bus.slot0_in    = 20'($urandom);
                bus.slot1_in    = 20'($urandom);
                bus.slot2_in    = 20'($urandom);
                bus.slot3_in    = 20'($urandom);
                bus.slot4_in    = 20'($urandom);
            end
            if (k == 100 && mid_apply) drive_boundary();
            if (k == 255) drive_boundary();
        end
        exp_sync = {16'hFFFF, 240'h0};
        if (first_after_rst) exp_sync[255] = 1'b0;
        check_val("tag",        256'(sd_v[255:240]), 256'(exp_frame[255:240]));
        check_val("slot1",      256'(sd_v[239:220]), 256'(exp_frame[239:220]));
        check_val("slot2",      256'(sd_v[219:200]), 256'(exp_frame[219:200]));
        check_val("slot3",      256'(sd_v[199:180]), 256'(exp_frame[199:180]));
        check_val("slot4",      256'(sd_v[179:160]), 256'(exp_frame[179:160]));
        check_val("slots5_12",  256'(sd_v[159:0]),   '0);
        check_val("sync",       sy_v, exp_sync);
        check_val("sample_req", sr_v, 256'(1));
        check_val("init_done",  id_v, {256{exp_run}});
        first_after_rst = 1'b0;
        model_boundary();
    endtask

    initial begin
        rst_n = 1'b0;
        b_ready = 1'b0;
        b_s0 = '0; b_s1 = '0; b_s2 = '0; b_s3 = '0; b_s4 = '0;
        drive_boundary();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: not ready, all-zero frames.
        run_frame(-1, 1'b0, 1'b1);
        run_frame(-1, 1'b0, 1'b0);

        // Bring-up with fixed RUN content.
        b_ready = 1'b1;
        b_s0 = 20'h0F800; b_s1 = 20'h04000; b_s2 = 20'h00000;
        b_s3 = 20'hABCDE; b_s4 = 20'hABCDE;
        repeat (CMD_FRAMES + 1) run_frame(-1, 1'b0, 1'b1);

        // Fixed RUN frame while slot3 changes at bit 100; new value shows next frame.
        b_s3 = 20'h12345;
        run_frame(-1, 1'b1, 1'b0);
        run_frame(-1, 1'b0, 1'b0);

        // Randomised traffic including occasional codec_ready drops.
        repeat (8) begin
            b_ready = ($urandom_range(0, 7) != 0);
            rand_slots();
            run_frame(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Drop and re-raise: command sequence repeats.
        b_ready = 1'b0;
        rand_slots();
        run_frame(-1, 1'b0, 1'b1);
        b_ready = 1'b1;
        repeat (CMD_FRAMES + 2) begin
            rand_slots();
            run_frame(-1, 1'b0, 1'b1);
        end

        // Reset mid-frame at bit 150, then recover with codec_ready held high.
        run_frame(150, 1'b0, 1'b0);
        repeat (CMD_FRAMES + 3) begin
            rand_slots();
            run_frame(-1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
